tma_lsu_mem_arb: RTL and testbench

- Shares one LSU block's memory request/response channel into the memory unit between the core LSU and the TMA engine.
- Arbitrates requests round-robin and tags each with its source.
- Registers the granted request into a one-deep output stage and routes responses back by tag MSB.
- Throttles TMA reads with an outstanding-read credit counter so bulk TMA copies cannot starve LSU latency.

---
 rtl/tma_lsu_mem_arb_pkg.sv | 39 +++
 rtl/tma_lsu_mem_arb_req_buf.sv | 38 +++
 rtl/tma_lsu_mem_arb.sv | 129 ++++++++++++
 tb/tb_tma_lsu_mem_arb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tma_lsu_mem_arb_pkg.sv
// Shared types and width helpers for the LSU/TMA memory-channel arbiter.
// The packed structs describe the default 4-lane, 4-byte, 32-bit-address layout.
package tma_lsu_mem_arb_pkg;

  typedef enum logic {
    SRC_LSU = 1'b0,
    SRC_TMA = 1'b1
  } tma_arb_src_e;

  localparam logic TMA_ARB_SRC_TMA = 1'b1;

  localparam int TMA_ARB_DEF_LANES = 4;
  localparam int TMA_ARB_DEF_WSIZE = 4;
  localparam int TMA_ARB_DEF_AWIDTH = 32;

  typedef struct packed {
    logic                                                    rw;
    logic [TMA_ARB_DEF_LANES-1:0]                            mask;
    logic [TMA_ARB_DEF_LANES-1:0][TMA_ARB_DEF_WSIZE-1:0]     byteen;
    logic [TMA_ARB_DEF_LANES-1:0][TMA_ARB_DEF_AWIDTH-1:0]    addr;
    logic [TMA_ARB_DEF_LANES-1:0][8*TMA_ARB_DEF_WSIZE-1:0]   data;
  } tma_arb_req_t;

  typedef struct packed {
    logic [TMA_ARB_DEF_LANES-1:0]                            mask;
    logic [TMA_ARB_DEF_LANES-1:0][8*TMA_ARB_DEF_WSIZE-1:0]   data;
    logic                                                    sop;
    logic                                                    eop;
  } tma_arb_rsp_t;

  function automatic int tma_arb_req_w(input int lanes, input int wsize, input int awidth);
    return 1 + lanes + lanes * wsize + lanes * awidth + lanes * 8 * wsize;
  endfunction

  function automatic int tma_arb_rsp_w(input int lanes, input int wsize);
    return lanes + lanes * 8 * wsize + 2;
  endfunction

endpackage

// File: rtl/tma_lsu_mem_arb_req_buf.sv
// One-entry elastic register: accepts a new word whenever it is empty or
// its current word is being taken in the same cycle.
module tma_arb_req_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
    end
  end

  // Payload needs no reset: it is only observed while valid_q is set.
  always_ff @(posedge clk) begin
    if (in_valid_i && in_ready_o) begin
      data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/tma_lsu_mem_arb.sv
// Shares one memory request/response channel between the core LSU and the TMA
// engine: round-robin grant, source-tagged registered output, credit-limited TMA reads.
module tma_lsu_mem_arb
  import tma_lsu_mem_arb_pkg::*;
#(
  parameter int NUM_LANES       = 4,
  parameter int WORD_SIZE       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int LSU_TAG_WIDTH   = 16,
  parameter int TMA_TAG_WIDTH   = 8,
  parameter int TMA_MAX_PENDING = 8,
  localparam int REQ_W     = tma_arb_req_w(NUM_LANES, WORD_SIZE, ADDR_WIDTH),
  localparam int RSP_W     = tma_arb_rsp_w(NUM_LANES, WORD_SIZE),
  localparam int SRC_TAG_W = (LSU_TAG_WIDTH > TMA_TAG_WIDTH) ? LSU_TAG_WIDTH : TMA_TAG_WIDTH,
  localparam int OUT_TAG_W = SRC_TAG_W + 1,
  localparam int INF_W     = $clog2(TMA_MAX_PENDING + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lsu_req_valid,
  input  logic [REQ_W-1:0]         lsu_req_data,
  input  logic [LSU_TAG_WIDTH-1:0] lsu_req_tag,
  output logic                     lsu_req_ready,
  input  logic                     tma_req_valid,
  input  logic [REQ_W-1:0]         tma_req_data,
  input  logic [TMA_TAG_WIDTH-1:0] tma_req_tag,
  output logic                     tma_req_ready,
  output logic                     mem_req_valid,
  output logic [REQ_W-1:0]         mem_req_data,
  output logic [OUT_TAG_W-1:0]     mem_req_tag,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [RSP_W-1:0]         mem_rsp_data,
  input  logic [OUT_TAG_W-1:0]     mem_rsp_tag,
  output logic                     mem_rsp_ready,
  output logic                     lsu_rsp_valid,
  output logic [RSP_W-1:0]         lsu_rsp_data,
  output logic [LSU_TAG_WIDTH-1:0] lsu_rsp_tag,
  input  logic                     lsu_rsp_ready,
  output logic                     tma_rsp_valid,
  output logic [RSP_W-1:0]         tma_rsp_data,
  output logic [TMA_TAG_WIDTH-1:0] tma_rsp_tag,
  input  logic                     tma_rsp_ready,
  output logic [INF_W-1:0]         tma_inflight,
  output logic                     busy
);

  localparam logic [INF_W-1:0] MAX_PEND = INF_W'(TMA_MAX_PENDING);

  tma_arb_src_e           last_grant_q;
  logic [INF_W-1:0]       inflight_q, inflight_d;
  logic                   tma_is_wr, lsu_elig, tma_elig, any_elig, grant_tma;
  logic                   can_load, accept, tma_rd_acc;
  logic                   rsp_to_tma, tma_eop_hs;
  logic [REQ_W-1:0]       win_data;
  logic [OUT_TAG_W-1:0]   win_tag;

  // Request side: eligibility, strict alternation when both compete.
  always_comb begin
    tma_is_wr  = tma_req_data[REQ_W-1];
    lsu_elig   = reset && lsu_req_valid;
    tma_elig   = reset && tma_req_valid && (tma_is_wr || (inflight_q < MAX_PEND));
    any_elig   = lsu_elig || tma_elig;
    grant_tma  = tma_elig && (!lsu_elig || (last_grant_q == SRC_LSU));
    accept     = any_elig && can_load;
    tma_rd_acc = accept && grant_tma && !tma_is_wr;
    win_data   = grant_tma ? tma_req_data : lsu_req_data;
    win_tag    = grant_tma ? {TMA_ARB_SRC_TMA, SRC_TAG_W'(tma_req_tag)}
                           : {~TMA_ARB_SRC_TMA, SRC_TAG_W'(lsu_req_tag)};
  end

  assign lsu_req_ready = can_load && lsu_elig && !grant_tma;
  assign tma_req_ready = can_load && grant_tma;

  tma_arb_req_buf #(
    .W(REQ_W + OUT_TAG_W)
  ) u_req_buf (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (any_elig),
    .in_data_i  ({win_tag, win_data}),
    .in_ready_o (can_load),
    .out_valid_o(mem_req_valid),
    .out_data_o ({mem_req_tag, mem_req_data}),
    .out_ready_i(mem_req_ready)
  );

  // Response side: purely combinational steering on the source bit.
  assign rsp_to_tma    = (mem_rsp_tag[OUT_TAG_W-1] == TMA_ARB_SRC_TMA);
  assign tma_rsp_valid = reset && mem_rsp_valid && rsp_to_tma;
  assign lsu_rsp_valid = reset && mem_rsp_valid && !rsp_to_tma;
  assign tma_rsp_data  = mem_rsp_data;
  assign lsu_rsp_data  = mem_rsp_data;
  assign tma_rsp_tag   = mem_rsp_tag[TMA_TAG_WIDTH-1:0];
  assign lsu_rsp_tag   = mem_rsp_tag[LSU_TAG_WIDTH-1:0];
  assign mem_rsp_ready = reset && (rsp_to_tma ? tma_rsp_ready : lsu_rsp_ready);
  assign tma_eop_hs    = tma_rsp_valid && tma_rsp_ready && mem_rsp_data[0];

  // Only the final beat of a read response returns a credit.
  always_comb begin
    inflight_d = inflight_q;
    if (tma_rd_acc && !tma_eop_hs) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!tma_rd_acc && tma_eop_hs && (inflight_q != '0)) begin
      inflight_d = inflight_q - INF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q   <= '0;
      last_grant_q <= SRC_TMA;
    end else begin
      inflight_q <= inflight_d;
      if (accept) begin
        last_grant_q <= grant_tma ? SRC_TMA : SRC_LSU;
      end
    end
  end

  assign tma_inflight = inflight_q;
  assign busy         = mem_req_valid || (inflight_q != '0);

`ifndef SYNTHESIS
  a_no_credit_underflow: assert property (@(posedge clk) disable iff (!reset)
    tma_eop_hs |-> (inflight_q != '0));
`endif

endmodule

// File: tb/tb_tma_lsu_mem_arb.sv
// Scoreboard bench for the LSU/TMA memory arbiter with a two-credit TMA read limit.
module tb_tma_lsu_mem_arb;
  localparam int NL = 4, WS = 4, AW = 32, LTW = 16, TTW = 8, MAXP = 2;
  localparam int REQ_W = 1 + NL + NL*WS + NL*AW + NL*8*WS;
  localparam int RSP_W = NL + NL*8*WS + 2;
  localparam int OTW   = 17;
  localparam int INF_W = 2;

  logic             clk, reset;
  logic             lsu_req_valid, lsu_req_ready, tma_req_valid, tma_req_ready;
  logic [REQ_W-1:0] lsu_req_data, tma_req_data, mem_req_data;
  logic [LTW-1:0]   lsu_req_tag, lsu_rsp_tag;
  logic [TTW-1:0]   tma_req_tag, tma_rsp_tag;
  logic             mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic [OTW-1:0]   mem_req_tag, mem_rsp_tag;
  logic [RSP_W-1:0] mem_rsp_data, lsu_rsp_data, tma_rsp_data;
  logic             lsu_rsp_valid, lsu_rsp_ready, tma_rsp_valid, tma_rsp_ready;
  logic [INF_W-1:0] tma_inflight;
  logic             busy;

  tma_lsu_mem_arb #(
    .NUM_LANES(NL), .WORD_SIZE(WS), .ADDR_WIDTH(AW),
    .LSU_TAG_WIDTH(LTW), .TMA_TAG_WIDTH(TTW), .TMA_MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .reset(reset),
    .lsu_req_valid(lsu_req_valid), .lsu_req_data(lsu_req_data), .lsu_req_tag(lsu_req_tag),
    .lsu_req_ready(lsu_req_ready),
    .tma_req_valid(tma_req_valid), .tma_req_data(tma_req_data), .tma_req_tag(tma_req_tag),
    .tma_req_ready(tma_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_tag(lsu_rsp_tag),
    .lsu_rsp_ready(lsu_rsp_ready),
    .tma_rsp_valid(tma_rsp_valid), .tma_rsp_data(tma_rsp_data), .tma_rsp_tag(tma_rsp_tag),
    .tma_rsp_ready(tma_rsp_ready),
    .tma_inflight(tma_inflight), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [REQ_W-1:0] data; logic [LTW-1:0] tag; } src_t;
  typedef struct { logic [REQ_W-1:0] data; logic [OTW-1:0] tag; } exp_t;

  src_t lsu_q[$];
  src_t tma_q[$];
  exp_t exp_q[$];

  int               n_checks = 0;
  int               n_pass = 0;
  logic             stall_prev, acc_prev;
  logic [REQ_W-1:0] prev_data;
  logic [OTW-1:0]   prev_tag;

  task automatic chk(input string name, input logic [287:0] got, input logic [287:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  function automatic logic [REQ_W-1:0] rand_req(input logic rw);
    logic [287:0]     r;
    logic [REQ_W-1:0] v;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    v = r[REQ_W-1:0];
    v[REQ_W-1] = rw;
    return v;
  endfunction

  function automatic logic [RSP_W-1:0] rand_rsp(input logic sop, input logic eop);
    logic [159:0]     r;
    logic [RSP_W-1:0] v;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    v = r[RSP_W-1:0];
    v[1] = sop;
    v[0] = eop;
    return v;
  endfunction

  task automatic add_lsu();
    src_t s;
    exp_t e;
    s.data = rand_req(1'($urandom_range(0, 1)));
    s.tag  = 16'($urandom());
    lsu_q.push_back(s);
    e.data = s.data;
    e.tag  = {1'b0, s.tag};
    exp_q.push_back(e);
  endtask

  task automatic add_tma(input logic rw);
    src_t s;
    exp_t e;
    s.data = rand_req(rw);
    s.tag  = {8'h00, 8'($urandom())};
    tma_q.push_back(s);
    e.data = s.data;
    e.tag  = {1'b1, s.tag};
    exp_q.push_back(e);
  endtask

  task automatic present();
    lsu_req_valid = (lsu_q.size() > 0);
    tma_req_valid = (tma_q.size() > 0);
    if (lsu_q.size() > 0) begin
      lsu_req_data = lsu_q[0].data;
      lsu_req_tag  = lsu_q[0].tag;
    end
    if (tma_q.size() > 0) begin
      tma_req_data = tma_q[0].data;
      tma_req_tag  = tma_q[0].tag[TTW-1:0];
    end
  endtask

  // One clock: sample/score at the falling edge, advance drivers after the rising edge.
  task automatic step();
    logic la, ta, hs;
    exp_t e;
    @(negedge clk);
    la = lsu_req_valid && lsu_req_ready;
    ta = tma_req_valid && tma_req_ready;
    hs = mem_req_valid && mem_req_ready;
    if (acc_prev) chk("out_latency", mem_req_valid, 1'b1);
    if (stall_prev) begin
      chk("stall_data", mem_req_data, prev_data);
      chk("stall_tag", mem_req_tag, prev_tag);
    end
    if (mem_req_valid && !mem_req_ready) chk("stall_readies", {lsu_req_ready, tma_req_ready}, 2'b00);
    if (hs) begin
      chk("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req_tag", mem_req_tag, e.tag);
        chk("req_data", mem_req_data, e.data);
      end
    end
    stall_prev = mem_req_valid && !mem_req_ready;
    prev_data  = mem_req_data;
    prev_tag   = mem_req_tag;
    acc_prev   = la || ta;
    @(posedge clk);
    #1;
    if (la) void'(lsu_q.pop_front());
    if (ta) void'(tma_q.pop_front());
    present();
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || lsu_q.size() > 0 || tma_q.size() > 0) && n < max) begin
      step();
      n++;
    end
    chk(name, n < max, 1'b1);
  endtask

  logic [RSP_W-1:0] rsp;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    stall_prev = 1'b0;
    acc_prev   = 1'b0;
    reset = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_data = rand_req(1'b0); lsu_req_tag = 16'h1111;
    tma_req_valid = 1'b1; tma_req_data = rand_req(1'b0); tma_req_tag = 8'h22;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_tag = {1'b1, 16'h0001}; mem_rsp_data = rand_rsp(1'b1, 1'b1);
    lsu_rsp_ready = 1'b1; tma_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_lsu_req_ready", lsu_req_ready, 1'b0);
    chk("rst_tma_req_ready", tma_req_ready, 1'b0);
    chk("rst_rsp_valids", {lsu_rsp_valid, tma_rsp_valid}, 2'b00);
    chk("rst_mem_rsp_ready", mem_rsp_ready, 1'b0);
    chk("rst_inflight", tma_inflight, 2'd0);
    chk("rst_busy", busy, 1'b0);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    present();
    reset = 1'b1;
    step();
    step();

    // Alternation: both sources continuously valid, LSU first after reset.
    for (int i = 0; i < 4; i++) begin
      add_lsu();
      add_tma(1'b1);
    end
    present();
    drain("alt_drain", 40);

    // Backpressure: five stalled cycles in the middle of a stream.
    for (int i = 0; i < 4; i++) begin
      add_lsu();
      add_tma(1'b1);
    end
    present();
    step();
    step();
    mem_req_ready = 1'b0;
    repeat (5) step();
    mem_req_ready = 1'b1;
    drain("bp_drain", 40);

    // Credit limit: third TMA read stalls while the LSU keeps flowing.
    for (int i = 0; i < 3; i++) begin
      add_lsu();
      add_tma(1'b0);
    end
    present();
    n = 0;
    while (!(lsu_q.size() == 0 && exp_q.size() == 1) && n < 30) begin
      step();
      n++;
    end
    chk("credit_wait", n < 30, 1'b1);
    repeat (3) step();
    chk("credit_stall_ready", tma_req_ready, 1'b0);
    chk("credit_inflight", tma_inflight, 2'd2);
    chk("credit_pending", exp_q.size(), 1);
    chk("busy_inflight", busy, 1'b1);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {1'b1, 8'h00, 8'h01};
    mem_rsp_data  = rand_rsp(1'b1, 1'b1);
    step();
    mem_rsp_valid = 1'b0;
    chk("credit_dec", tma_inflight, 2'd1);
    drain("credit_drain", 10);
    chk("credit_refill", tma_inflight, 2'd2);

    // A TMA write goes through with no credits left.
    add_tma(1'b1);
    present();
    drain("wr_drain", 10);
    chk("wr_bypass", tma_inflight, 2'd2);

    // Response routing: two-beat TMA read response, then an LSU response.
    rsp = rand_rsp(1'b1, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {1'b1, 8'h00, 8'h5A};
    mem_rsp_data  = rsp;
    #1;
    chk("rsp1_valids", {tma_rsp_valid, lsu_rsp_valid}, 2'b10);
    chk("rsp1_tag", tma_rsp_tag, 8'h5A);
    chk("rsp1_data", tma_rsp_data, rsp);
    chk("rsp1_ready", mem_rsp_ready, 1'b1);
    step();
    chk("rsp1_inflight", tma_inflight, 2'd2);
    rsp = rand_rsp(1'b0, 1'b1);
    mem_rsp_data = rsp;
    #1;
    chk("rsp2_tag", tma_rsp_tag, 8'h5A);
    step();
    chk("rsp2_inflight", tma_inflight, 2'd1);
    rsp = rand_rsp(1'b1, 1'b1);
    mem_rsp_tag   = {1'b0, 16'h1234};
    mem_rsp_data  = rsp;
    lsu_rsp_ready = 1'b0;
    #1;
    chk("lrsp_valids", {tma_rsp_valid, lsu_rsp_valid}, 2'b01);
    chk("lrsp_tag", lsu_rsp_tag, 16'h1234);
    chk("lrsp_data", lsu_rsp_data, rsp);
    chk("lrsp_ready_low", mem_rsp_ready, 1'b0);
    lsu_rsp_ready = 1'b1;
    #1;
    chk("lrsp_ready_high", mem_rsp_ready, 1'b1);
    step();
    chk("lrsp_inflight", tma_inflight, 2'd1);
    mem_rsp_tag   = {1'b1, 8'h00, 8'h03};
    mem_rsp_data  = rand_rsp(1'b1, 1'b1);
    tma_rsp_ready = 1'b0;
    #1;
    chk("trsp_ready_low", mem_rsp_ready, 1'b0);
    tma_rsp_ready = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("final_inflight", tma_inflight, 2'd0);
    chk("final_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
